// File: rtl/bin_act_pool_pkg.sv
// Shared constants, FSM encoding and the binarize helper for bin_act_pool.
// Optional popcount output is controlled by BIN_ACT_POOL_POPCNT_EN (see top).
package bin_act_pool_pkg;

    localparam int NI0  = 28;
    localparam int NI1  = 26;
    localparam int K    = 3;
    localparam int OW0  = NI0 - K + 1;
    localparam int OW1  = NI1 - K + 1;
    localparam int LB_D = OW0 / 2;

    // din/thresh width, row/col counter width, line-buffer index width
    localparam int DW = 5;
    localparam int CW = $clog2(OW0);
    localparam int IW = $clog2(LB_D);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    function automatic logic binarize(input logic signed [DW-1:0] v,
                                      input logic signed [DW-1:0] t);
        return v >= t;
    endfunction

endpackage

// File: rtl/bin_act_pool_line_buf.sv
// One-bit-wide pooling line buffer: single write port, combinational read,
// cleared by synchronous reset.
module pool_line_buf
    import bin_act_pool_pkg::*;
#(
    parameter int DEPTH = LB_D,
    parameter int AW    = IW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic          wdata,
    input  logic [AW-1:0] raddr,
    output logic          rdata
);

    logic r_mem [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_mem[gi] <= 1'b0;
                end else if (we && (waddr == AW'(gi))) begin
                    r_mem[gi] <= wdata;
                end
            end
        end
    endgenerate

    // Indices past DEPTH cannot occur in normal operation; read as zero.
    assign rdata = (raddr < AW'(DEPTH)) ? r_mem[raddr] : 1'b0;

endmodule

// File: rtl/bin_act_pool.sv
// Binarize a signed conv stream against a threshold and 2x2/stride-2 OR-pool it.
// Define BIN_ACT_POOL_POPCNT_EN to add the ones_cnt output (pooled ones per frame).
module bin_act_pool
    import bin_act_pool_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          state,
    input  logic [DW-1:0] thresh,
    input  logic [DW-1:0] din,
    input  logic          ivalid,
    output logic          dout,
    output logic          ovalid,
    output logic          done
`ifdef BIN_ACT_POOL_POPCNT_EN
    ,
    output logic [7:0]    ones_cnt
`endif
);

    fsm_t          r_fsm;
    fsm_t          w_fsm_next;
    logic          r_layer;
    logic [DW-1:0] r_thresh;
    logic [CW-1:0] r_col;
    logic [CW-1:0] r_row;
    logic          r_hreg;
    logic          r_dout;
    logic          r_ovalid;
    logic          r_last;
    logic          r_done;

    logic          w_start_frame;
    logic          w_fire;
    logic          w_bin;
    logic          w_h;
    logic [CW-1:0] w_last_idx;
    logic          w_col_wrap;
    logic          w_final;
    logic          w_lb_we;
    logic          w_pair;
    logic [IW-1:0] w_lb_idx;
    logic          w_lb_rd;
    logic          w_pool;

    assign w_start_frame = (r_fsm == IDLE) && start;
    assign w_fire        = (r_fsm == RUN) && ivalid;
    assign w_bin         = binarize(din, r_thresh);
    assign w_h           = r_hreg | w_bin;
    assign w_last_idx    = r_layer ? CW'(OW1 - 1) : CW'(OW0 - 1);
    assign w_col_wrap    = (r_col == w_last_idx);
    assign w_final       = w_fire && w_col_wrap && (r_row == w_last_idx);
    assign w_lb_we       = w_fire && r_col[0] && !r_row[0];
    assign w_pair        = w_fire && r_col[0] && r_row[0];
    assign w_lb_idx      = r_col[CW-1:1];
    assign w_pool        = w_lb_rd | w_h;

    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            IDLE:    if (start) w_fsm_next = RUN;
            RUN:     if (w_final) w_fsm_next = DONE;
            DONE:    w_fsm_next = DONE;
            default: w_fsm_next = IDLE;
        endcase
        // Dropping start aborts from any state without a done pulse.
        if (!start) w_fsm_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm <= IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_layer  <= 1'b0;
            r_thresh <= '0;
        end else if (w_start_frame) begin
            r_layer  <= state;
            r_thresh <= thresh;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (r_fsm != RUN)) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_fire) begin
            if (w_col_wrap) begin
                r_col <= '0;
                r_row <= r_row + CW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hreg <= 1'b0;
        end else if (w_fire && !r_col[0]) begin
            r_hreg <= w_bin;
        end
    end

    pool_line_buf #(
        .DEPTH (LB_D),
        .AW    (IW)
    ) u_line_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (w_lb_we),
        .waddr (w_lb_idx),
        .wdata (w_h),
        .raddr (w_lb_idx),
        .rdata (w_lb_rd)
    );

    // done trails the final ovalid by one cycle so the two never overlap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout   <= 1'b0;
            r_ovalid <= 1'b0;
            r_last   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_ovalid <= w_pair;
            r_last   <= w_final;
            r_done   <= r_last && start;
            if (w_pair) begin
                r_dout <= w_pool;
            end
        end
    end

    assign dout   = r_dout;
    assign ovalid = r_ovalid;
    assign done   = r_done;

`ifdef BIN_ACT_POOL_POPCNT_EN
    logic [7:0] r_ones;

    always_ff @(posedge clk) begin
        if (rst || w_start_frame) begin
            r_ones <= '0;
        end else if (w_pair && w_pool) begin
            r_ones <= r_ones + 8'd1;
        end
    end

    assign ones_cnt = r_ones;
`endif

endmodule
